// File: rtl/tp1_montre_cpu_oci_dct_packer.sv
// ---------------------------------------------------------------------------
// tp1_montre_cpu_oci_dct_packer
//
// Purpose: writer side of the OCI DCT trace path. The block packs 2-bit
// atoms into a 30-bit frame and counts them. It hands completed or flushed
// frames to the trace FIFO over a valid/ready handshake. The atom stream
// cannot be stalled, so atoms that arrive while both the accumulator and the
// output register are full are dropped and counted.
//
// Ports:
//   clk, reset_n              system clock, async active-low reset
//   trace_enable              atoms accepted only while high; a 1->0 edge
//                             emits any partial frame
//   atom_valid, atom_code     atom input
//   flush                     pulse: emit the partial frame
//   frame_valid/frame_ready   output handshake
//   frame_data, frame_count   packed atoms (oldest in the highest bits), 1..15
//   overflow, drop_count      sticky drop flag, saturating drop counter
//   frame_timestamp           (TP1_MONTRE_DCT_TIMESTAMP_EN only) cycle count
//                             sampled when the frame's first atom was accepted
//
// Optional feature macro: TP1_MONTRE_DCT_TIMESTAMP_EN
//
// state        | meaning
// -------------+-----------------------------------------------------------
// S_EMPTY      | accumulator holds no atoms
// S_FILLING    | 1..14 atoms held, no emit pending
// S_FULL_WAIT  | 15 atoms held, waiting for the output register; drops atoms
// S_PEND_FLUSH | partial frame must be emitted; still appending atoms
// ---------------------------------------------------------------------------
module tp1_montre_cpu_oci_dct_packer #(
    parameter int ATOM_W = 2,
    parameter int ATOMS  = 15,
    parameter int CNT_W  = 4,
    parameter int BUF_W  = 30
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              trace_enable,
    input  logic              atom_valid,
    input  logic [ATOM_W-1:0] atom_code,
    input  logic              flush,
    output logic              frame_valid,
    input  logic              frame_ready,
    output logic [BUF_W-1:0]  frame_data,
    output logic [CNT_W-1:0]  frame_count,
    output logic              overflow,
    output logic [7:0]        drop_count
`ifdef TP1_MONTRE_DCT_TIMESTAMP_EN
    ,
    output logic [15:0]       frame_timestamp
`endif
);

    typedef enum logic [1:0] {
        S_EMPTY,
        S_FILLING,
        S_FULL_WAIT,
        S_PEND_FLUSH
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ATOMS - 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(ATOMS);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    state_t             r_state;
    logic [BUF_W-1:0]   r_acc;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_te_q;

    state_t             w_state_nxt;
    logic [BUF_W-1:0]   w_acc_nxt;
    logic [CNT_W-1:0]   w_cnt_nxt;
    logic               w_emit;
    logic [BUF_W-1:0]   w_emit_data;
    logic [CNT_W-1:0]   w_emit_cnt;
    logic               w_drop;
    logic               w_first;

    logic               w_accept;
    logic               w_te_fall;
    logic               w_out_free;
    logic [BUF_W-1:0]   w_acc_app;
    logic [BUF_W-1:0]   w_acc_new;

    assign w_accept   = atom_valid && trace_enable;
    assign w_te_fall  = r_te_q && !trace_enable;
    // A transfer this cycle frees the output register for a same-cycle reload.
    assign w_out_free = !frame_valid || frame_ready;
    assign w_acc_app  = {r_acc[BUF_W-ATOM_W-1:0], atom_code};
    assign w_acc_new  = {{(BUF_W-ATOM_W){1'b0}}, atom_code};

    always_comb begin
        w_state_nxt = r_state;
        w_acc_nxt   = r_acc;
        w_cnt_nxt   = r_cnt;
        w_emit      = 1'b0;
        w_emit_data = r_acc;
        w_emit_cnt  = r_cnt;
        w_drop      = 1'b0;
        w_first     = 1'b0;
        case (r_state)
            S_EMPTY: begin
                // A flush with nothing held is simply ignored.
                if (w_accept) begin
                    w_acc_nxt   = w_acc_new;
                    w_cnt_nxt   = CNT_ONE;
                    w_first     = 1'b1;
                    w_state_nxt = S_FILLING;
                end
            end
            S_FILLING, S_PEND_FLUSH: begin
                if (w_accept && r_cnt == CNT_LAST) begin
                    // The completing atom always belongs to its own frame.
                    w_emit_data = w_acc_app;
                    w_emit_cnt  = CNT_FULL;
                    if (w_out_free) begin
                        w_emit      = 1'b1;
                        w_acc_nxt   = '0;
                        w_cnt_nxt   = '0;
                        w_state_nxt = S_EMPTY;
                    end else begin
                        w_acc_nxt   = w_acc_app;
                        w_cnt_nxt   = CNT_FULL;
                        w_state_nxt = S_FULL_WAIT;
                    end
                end else if (r_state == S_PEND_FLUSH || flush || w_te_fall) begin
                    if (w_out_free) begin
                        // Emitted frame excludes a same-cycle atom; that atom
                        // opens the next frame.
                        w_emit = 1'b1;
                        if (w_accept) begin
                            w_acc_nxt   = w_acc_new;
                            w_cnt_nxt   = CNT_ONE;
                            w_first     = 1'b1;
                            w_state_nxt = S_FILLING;
                        end else begin
                            w_acc_nxt   = '0;
                            w_cnt_nxt   = '0;
                            w_state_nxt = S_EMPTY;
                        end
                    end else begin
                        w_state_nxt = S_PEND_FLUSH;
                        if (w_accept) begin
                            w_acc_nxt = w_acc_app;
                            w_cnt_nxt = r_cnt + 1'b1;
                        end
                    end
                end else if (w_accept) begin
                    w_acc_nxt = w_acc_app;
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            S_FULL_WAIT: begin
                if (w_out_free) begin
                    w_emit = 1'b1;
                    if (w_accept) begin
                        w_acc_nxt   = w_acc_new;
                        w_cnt_nxt   = CNT_ONE;
                        w_first     = 1'b1;
                        w_state_nxt = S_FILLING;
                    end else begin
                        w_acc_nxt   = '0;
                        w_cnt_nxt   = '0;
                        w_state_nxt = S_EMPTY;
                    end
                end else if (w_accept) begin
                    w_drop = 1'b1;
                end
            end
            default: begin
                w_acc_nxt   = '0;
                w_cnt_nxt   = '0;
                w_state_nxt = S_EMPTY;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= S_EMPTY;
            r_acc       <= '0;
            r_cnt       <= '0;
            r_te_q      <= 1'b0;
            frame_valid <= 1'b0;
            frame_data  <= '0;
            frame_count <= '0;
            overflow    <= 1'b0;
            drop_count  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_acc   <= w_acc_nxt;
            r_cnt   <= w_cnt_nxt;
            r_te_q  <= trace_enable;
            if (w_emit) begin
                frame_valid <= 1'b1;
                frame_data  <= w_emit_data;
                frame_count <= w_emit_cnt;
            end else if (frame_valid && frame_ready) begin
                frame_valid <= 1'b0;
            end
            if (w_drop) begin
                overflow <= 1'b1;
                if (drop_count != 8'hFF) begin
                    drop_count <= drop_count + 8'd1;
                end
            end
        end
    end

`ifdef TP1_MONTRE_DCT_TIMESTAMP_EN
    logic [15:0] r_ts;
    logic [15:0] r_acc_ts;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_ts            <= '0;
            r_acc_ts        <= '0;
            frame_timestamp <= '0;
        end else begin
            r_ts <= r_ts + 16'd1;
            if (w_first) begin
                r_acc_ts <= r_ts;
            end
            // Old start stamp goes out even if a new frame starts this cycle.
            if (w_emit) begin
                frame_timestamp <= r_acc_ts;
            end
        end
    end
`endif

endmodule
